dtw_seq_source: RTL and testbench
=================================

DTW_SEQ_SOURCE -- requirements
Module: dtw_seq_source

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- SEQ_LEN, 20, words per R sequence.
- GAP_CYC, 10, idle cycles between the end of one sequence handshake and the next sequence fetch.
- ADDR_W, 10, memory address width.
- DATA_W, 32, data word width.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- i_clk, in, 1, single clock; all logic on the rising edge.
- i_rst, in, 1, synchronous reset, active-high.
- i_start, in, 1, single-cycle request to start a run; sampled in IDLE only.
- i_base_addr, in, ADDR_W, word address of the first word of sequence 0; latched on accepted start.
- i_num_seq, in, 4, number of sequences in the run (0..15); latched on accepted start.
- o_mem_addr, out, ADDR_W, memory word address.
- o_mem_CS, out, 1, memory chip select, active-low.
- o_mem_WR, out, 1, memory write strobe; 0 = read, 1 = write.
- i_mem_data, in, DATA_W, memory read bus; valid the cycle after an address is presented with CS low, and only while CS stays low.
- o_dtw_in, out, DATA_W, sequence word to the DTW processor.
- o_dtw_valid, out, 1, o_dtw_in carries a sequence word.
- i_dtw_ready, in, 1, DTW processor has produced its result and can take the next sequence.
- o_busy, out, 1, high from an accepted start until o_done.
- o_done, out, 1, one-cycle pulse at the end of a run.

Function
REQ-003 o_mem_WR SHALL be constant 0; the block only reads memory.
REQ-004 The FSM SHALL have the states IDLE, FETCH, WAIT_RDY, GAP and DONE.
REQ-005 Transitions:
- IDLE -> FETCH on i_start when i_num_seq != 0.
- IDLE -> DONE on i_start when i_num_seq == 0; no memory access occurs.
- FETCH -> WAIT_RDY after SEQ_LEN+2 cycles.
- WAIT_RDY -> GAP on i_dtw_ready == 1 while sequences remain.
- WAIT_RDY -> DONE on i_dtw_ready == 1 after the last sequence.
- GAP -> FETCH after GAP_CYC cycles.
- DONE -> IDLE after 1 cycle.
REQ-006 FETCH cycle timing, with cycle c = 0 as the first FETCH cycle:
- o_mem_CS SHALL be low for cycles 0..SEQ_LEN, i.e. exactly SEQ_LEN+1 consecutive cycles.
- o_mem_addr SHALL be A+c for c = 0..SEQ_LEN-1 and SHALL hold A+SEQ_LEN-1 at c = SEQ_LEN.
REQ-007 Address A of sequence s SHALL be (base + s*SEQ_LEN) mod 2^ADDR_W, and every per-word increment SHALL also wrap modulo 2^ADDR_W.
REQ-008 i_mem_data SHALL be registered in cycles 1..SEQ_LEN; o_dtw_in and o_dtw_valid SHALL come from that register. Word k SHALL appear with o_dtw_valid = 1 in cycle k+2. o_dtw_valid SHALL stay high for exactly SEQ_LEN consecutive cycles with no bubbles.
REQ-009 o_dtw_in SHALL be 0 whenever o_dtw_valid = 0.
REQ-010 In WAIT_RDY, i_dtw_ready SHALL be sampled only from the cycle after the last valid word. A ready level already present at that point SHALL count as the handshake.
REQ-011 o_mem_CS SHALL be high in IDLE, WAIT_RDY, GAP and DONE.
REQ-012 i_start SHALL be ignored while o_busy = 1. The latched base and count SHALL be unaffected by input changes during a run.
REQ-013 o_busy SHALL be 1 in FETCH, WAIT_RDY and GAP, and 0 in IDLE and DONE. o_done SHALL be 1 only in DONE.
REQ-014 A run of N sequences SHALL take N*(SEQ_LEN+2) FETCH cycles, plus WAIT_RDY time, plus (N-1)*GAP_CYC cycles.

Reset
REQ-015 While i_rst = 1 at a clock edge the block SHALL enter IDLE and clear all counters.
REQ-016 After reset the outputs SHALL be: o_mem_CS = 1, o_mem_WR = 0, o_mem_addr = 0, o_dtw_valid = 0, o_dtw_in = 0, o_busy = 0, o_done = 0.
REQ-017 A reset in the middle of a run SHALL abort it on that edge with no o_done pulse. The next cycle SHALL show CS high and valid low.

Structure
REQ-018 The FSM state encoding and the default SEQ_LEN, ADDR_W and DATA_W constants SHALL live in the shared DTW package, which the DTW top-level also uses.
REQ-019 One sub-module, dtw_seq_addr_gen (base latch, sequence/word counters, wrap adder), is natural. The FSM and the data register SHALL stay in dtw_seq_source.

Verification
REQ-020 The bench SHALL use the existing behavioural memory model preloaded with MEM[i] = 0x100+i, and SHALL cover the following scenarios:
- Start, base = 0, num = 1, ready tied high: exactly 21 CS-low cycles; valid cycles 2..21 carry 0x100..0x113; o_done pulses once.
- num = 3, base = 0x010, ready rising 5 cycles after each last word: sequences carry 0x110.., 0x124.., 0x138..; each fetch starts exactly 10 cycles after the ready handshake.
- base = 0x3F8, num = 1: addresses 0x3F8..0x3FF, then 0x000..0x00B; data wraps accordingly.
- num = 0: o_done in the cycle after start; CS never falls; valid stays 0.
- i_rst asserted at word 7 of sequence 1: the next cycle shows CS = 1, valid = 0, busy = 0; no o_done; a new start then runs cleanly.
- i_start pulsed during FETCH and during GAP: ignored; word count and addresses unchanged.

Source files
------------

// File: rtl/dtw_seq_source_pkg.sv
// rtl/dtw_seq_source_pkg.sv - shared DTW constants and sequence-source FSM encoding
package dtw_seq_source_pkg;

  localparam int DTW_SEQ_LEN = 20;
  localparam int DTW_ADDR_W  = 10;
  localparam int DTW_DATA_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RDY,
    GAP,
    DONE
  } seq_state_t;

  // Bits needed for a counter that must reach the larger of two terminal values.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dtw_seq_source_if.sv
// rtl/dtw_seq_source_if.sv - memory read bus and DTW sequence stream bundle
interface dtw_seq_source_if
  import dtw_seq_source_pkg::*;
#(
  parameter int ADDR_W = DTW_ADDR_W,
  parameter int DATA_W = DTW_DATA_W
);

  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_CS;
  logic              o_mem_WR;
  logic [DATA_W-1:0] i_mem_data;
  logic [DATA_W-1:0] o_dtw_in;
  logic              o_dtw_valid;
  logic              i_dtw_ready;

  modport master (
    output o_mem_addr, o_mem_CS, o_mem_WR, o_dtw_in, o_dtw_valid,
    input  i_mem_data, i_dtw_ready
  );

  modport slave (
    input  o_mem_addr, o_mem_CS, o_mem_WR, o_dtw_in, o_dtw_valid,
    output i_mem_data, i_dtw_ready
  );

endinterface

// File: rtl/dtw_seq_addr_gen.sv
// rtl/dtw_seq_addr_gen.sv - base latch, sequence/word counters and wrapping address adder
module dtw_seq_addr_gen #(
  parameter int SEQ_LEN = 20,
  parameter int ADDR_W  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [3:0]        i_num,
  input  logic              i_word_clr,
  input  logic              i_word_inc,
  input  logic              i_seq_next,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_seq
);

  localparam int WORD_W = (SEQ_LEN < 2) ? 1 : $clog2(SEQ_LEN);
  localparam logic [ADDR_W-1:0] SEQ_STEP = ADDR_W'(SEQ_LEN);

  logic [ADDR_W-1:0] seq_base;
  logic [WORD_W-1:0] word;
  logic [3:0]        seq_left;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seq_base <= '0;
      seq_left <= '0;
      word     <= '0;
    end else begin
      if (i_load) begin
        seq_base <= i_base;
        seq_left <= i_num;
      end else if (i_seq_next) begin
        seq_base <= seq_base + SEQ_STEP;
        seq_left <= seq_left - 4'd1;
      end
      if (i_word_clr) begin
        word <= '0;
      end else if (i_word_inc) begin
        word <= word + WORD_W'(1);
      end
    end
  end

  // Address arithmetic is naturally modulo 2^ADDR_W.
  assign o_addr     = seq_base + ADDR_W'(word);
  assign o_last_seq = (seq_left == 4'd1);

endmodule

// File: rtl/dtw_seq_source.sv
// rtl/dtw_seq_source.sv - fetches fixed-length sequences from memory and streams them to a DTW core
module dtw_seq_source
  import dtw_seq_source_pkg::*;
#(
  parameter int SEQ_LEN = DTW_SEQ_LEN,
  parameter int GAP_CYC = 10,
  parameter int ADDR_W  = DTW_ADDR_W,
  parameter int DATA_W  = DTW_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [3:0]        i_num_seq,
  output logic              o_busy,
  output logic              o_done,
  dtw_seq_source_if.master  bus
);

  localparam int CNT_W = cnt_width(SEQ_LEN + 1, GAP_CYC);
  localparam logic [CNT_W-1:0] C_WORD_LAST  = CNT_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0] C_CS_LAST    = CNT_W'(SEQ_LEN);
  localparam logic [CNT_W-1:0] C_FETCH_LAST = CNT_W'(SEQ_LEN + 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(GAP_CYC - 1);

  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              cs_n;
  logic              dtw_valid;
  logic [DATA_W-1:0] dtw_data;
  logic              busy;
  logic              done;
  logic              last_seq;
  logic [ADDR_W-1:0] addr;

  dtw_seq_addr_gen #(
    .SEQ_LEN (SEQ_LEN),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     ((state == IDLE) && i_start),
    .i_base     (i_base_addr),
    .i_num      (i_num_seq),
    .i_word_clr (state != FETCH),
    .i_word_inc ((state == FETCH) && (cnt < C_WORD_LAST)),
    .i_seq_next ((state == WAIT_RDY) && bus.i_dtw_ready && !last_seq),
    .o_addr     (addr),
    .o_last_seq (last_seq)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cs_n      <= 1'b1;
      dtw_valid <= 1'b0;
      dtw_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      dtw_valid <= 1'b0;
      dtw_data  <= '0;
      case (state)
        IDLE: begin
          if (i_start) begin
            cnt <= '0;
            if (i_num_seq != 4'd0) begin
              state <= FETCH;
              cs_n  <= 1'b0;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        FETCH: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == C_CS_LAST) cs_n <= 1'b1;
          // Memory returns word k one cycle after its address, so capture in cycles 1..SEQ_LEN.
          if ((cnt != '0) && (cnt <= C_CS_LAST)) begin
            dtw_valid <= 1'b1;
            dtw_data  <= bus.i_mem_data;
          end
          if (cnt == C_FETCH_LAST) begin
            state <= WAIT_RDY;
            cnt   <= '0;
          end
        end
        WAIT_RDY: begin
          if (bus.i_dtw_ready) begin
            if (last_seq) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
              cnt   <= '0;
            end
          end
        end
        GAP: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == C_GAP_LAST) begin
            state <= FETCH;
            cnt   <= '0;
            cs_n  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_mem_addr  = addr;
  assign bus.o_mem_CS    = cs_n;
  assign bus.o_mem_WR    = 1'b0;
  assign bus.o_dtw_in    = dtw_data;
  assign bus.o_dtw_valid = dtw_valid;
  assign o_busy          = busy;
  assign o_done          = done;

endmodule

// File: tb/tb_dtw_seq_source.sv
// tb/tb_dtw_seq_source.sv - scoreboard bench for dtw_seq_source with behavioural memory
`timescale 1ns/1ps
module tb_dtw_seq_source;

  localparam int SEQ_LEN = 20;
  localparam int GAP_CYC = 10;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int BOUND   = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [3:0]        num;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cs_low_cnt = 0;
  int valid_cnt = 0;
  int done_cnt = 0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] data_q[$];
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  dtw_seq_source_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dtw_seq_source #(
    .SEQ_LEN (SEQ_LEN),
    .GAP_CYC (GAP_CYC),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base_addr (base),
    .i_num_seq   (num),
    .o_busy      (busy),
    .o_done      (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h100 + 32'(i);
  end

  always @(posedge clk) begin
    if (!bus.o_mem_CS) bus.i_mem_data <= mem[bus.o_mem_addr];
    else               bus.i_mem_data <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!bus.o_mem_CS) begin
          cs_low_cnt++;
          chk("mem_wr", 32'(bus.o_mem_WR), 32'd0);
          if (addr_q.size() == 0) fail_now("mem_addr unexpected CS low");
          else chk("mem_addr", 32'(bus.o_mem_addr), 32'(addr_q.pop_front()));
        end
        if (bus.o_dtw_valid) begin
          valid_cnt++;
          if (data_q.size() == 0) fail_now("dtw_in unexpected valid");
          else chk("dtw_in", bus.o_dtw_in, data_q.pop_front());
        end else begin
          chk("dtw_in_idle_zero", bus.o_dtw_in, 32'd0);
        end
        if (done) done_cnt++;
      end
    end
  endtask

  task automatic push_seq(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] ad;
    for (int k = 0; k < SEQ_LEN; k++) begin
      ad = a + ADDR_W'(k);
      addr_q.push_back(ad);
      data_q.push_back(32'h100 + 32'(ad));
    end
    ad = a + ADDR_W'(SEQ_LEN - 1);
    addr_q.push_back(ad);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [3:0] n, output int s_cyc);
    @(negedge clk);
    base  = b;
    num   = n;
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    base  = ADDR_W'($urandom);
    num   = 4'($urandom);
  endtask

  task automatic wait_cs_low(input string name, output int c);
    c = -1;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (!bus.o_mem_CS) begin c = cyc; break; end
    end
    if (c < 0) fail_now({name, " timeout waiting for CS low"});
  endtask

  task automatic wait_valid(input string name, output int c);
    c = -1;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (bus.o_dtw_valid) begin c = cyc; break; end
    end
    if (c < 0) fail_now({name, " timeout waiting for valid"});
  endtask

  // Returns at the first negedge where valid is seen low after a valid burst.
  task automatic wait_valid_fall(input string name);
    int c;
    wait_valid(name, c);
    c = -1;
    for (int n = 0; n < BOUND; n++) begin
      if (!bus.o_dtw_valid) begin c = cyc; break; end
      @(negedge clk);
    end
    if (c < 0) fail_now({name, " timeout waiting for valid low"});
  endtask

  task automatic wait_done(input string name, output int d);
    d = -1;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (done) begin d = cyc; break; end
    end
    if (d < 0) fail_now({name, " timeout waiting for o_done"});
  endtask

  task automatic end_check(input string name, input int cs0, input int v0, input int d0,
                           input int exp_cs, input int exp_v, input int exp_d);
    repeat (2) @(negedge clk);
    chk({name, "_cs_low_cycles"}, 32'(cs_low_cnt - cs0), 32'(exp_cs));
    chk({name, "_valid_cycles"},  32'(valid_cnt - v0),   32'(exp_v));
    chk({name, "_done_pulses"},   32'(done_cnt - d0),    32'(exp_d));
    chk({name, "_addr_q_left"},   32'(addr_q.size()),    32'd0);
    chk({name, "_data_q_left"},   32'(data_q.size()),    32'd0);
  endtask

  initial begin
    int s, c, d, h, cs0, v0, d0;
    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    num   = '0;
    bus.i_dtw_ready = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_cs",    32'(bus.o_mem_CS),    32'd1);
    chk("rst_wr",    32'(bus.o_mem_WR),    32'd0);
    chk("rst_addr",  32'(bus.o_mem_addr),  32'd0);
    chk("rst_valid", 32'(bus.o_dtw_valid), 32'd0);
    chk("rst_dtw",   bus.o_dtw_in,         32'd0);
    chk("rst_busy",  32'(busy),            32'd0);
    chk("rst_done",  32'(done),            32'd0);
    rst = 1'b0;

    // Single sequence from 0 with ready tied high.
    bus.i_dtw_ready = 1'b1;
    cs0 = cs_low_cnt; v0 = valid_cnt; d0 = done_cnt;
    push_seq(10'h000);
    do_start(10'h000, 4'd1, s);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_cs_first", 32'(cyc - s), 32'd1);
    wait_valid("s1", c);
    chk("s1_valid_first", 32'(c - s), 32'd3);
    wait_done("s1", d);
    chk("s1_done_cycle", 32'(d - s), 32'd24);
    end_check("s1", cs0, v0, d0, 21, 20, 1);

    // Three sequences from 0x010, ready rises 5 cycles after each last word.
    bus.i_dtw_ready = 1'b0;
    cs0 = cs_low_cnt; v0 = valid_cnt; d0 = done_cnt;
    push_seq(10'h010);
    push_seq(10'h024);
    push_seq(10'h038);
    do_start(10'h010, 4'd3, s);
    for (int q = 0; q < 3; q++) begin
      wait_valid_fall("s2");
      repeat (4) @(negedge clk);
      chk("s2_busy_wait", 32'(busy), 32'd1);
      chk("s2_cs_wait", 32'(bus.o_mem_CS), 32'd1);
      bus.i_dtw_ready = 1'b1;
      h = cyc;
      @(negedge clk);
      bus.i_dtw_ready = 1'b0;
      if (q < 2) begin
        wait_cs_low("s2", c);
        chk("s2_gap_to_fetch", 32'(c - h), 32'(GAP_CYC + 1));
      end else begin
        chk("s2_done_after_ready", 32'(done), 32'd1);
      end
    end
    end_check("s2", cs0, v0, d0, 63, 60, 1);

    // Address wrap across the top of memory.
    bus.i_dtw_ready = 1'b1;
    cs0 = cs_low_cnt; v0 = valid_cnt; d0 = done_cnt;
    push_seq(10'h3F8);
    do_start(10'h3F8, 4'd1, s);
    wait_done("s3", d);
    end_check("s3", cs0, v0, d0, 21, 20, 1);

    // Zero sequences: immediate done, no memory access.
    cs0 = cs_low_cnt; v0 = valid_cnt; d0 = done_cnt;
    do_start(10'h123, 4'd0, s);
    chk("s4_done_next", 32'(done), 32'd1);
    chk("s4_busy", 32'(busy), 32'd0);
    end_check("s4", cs0, v0, d0, 0, 0, 1);

    // Reset in the middle of sequence 1, then a clean run.
    push_seq(10'h000);
    push_seq(10'h014);
    do_start(10'h000, 4'd2, s);
    c = -1;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (bus.o_dtw_valid && (bus.o_dtw_in == 32'h11B)) begin c = cyc; break; end
    end
    if (c < 0) fail_now("s5 timeout waiting for word 7 of sequence 1");
    rst = 1'b1;
    @(negedge clk);
    chk("s5_abort_cs",    32'(bus.o_mem_CS),    32'd1);
    chk("s5_abort_valid", 32'(bus.o_dtw_valid), 32'd0);
    chk("s5_abort_busy",  32'(busy),            32'd0);
    chk("s5_abort_done",  32'(done),            32'd0);
    rst = 1'b0;
    addr_q.delete();
    data_q.delete();
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    chk("s5_no_done", 32'(done_cnt - d0), 32'd0);
    cs0 = cs_low_cnt; v0 = valid_cnt; d0 = done_cnt;
    push_seq(10'h005);
    do_start(10'h005, 4'd1, s);
    wait_done("s5b", d);
    end_check("s5b", cs0, v0, d0, 21, 20, 1);

    // Start pulses during FETCH and GAP must be ignored.
    cs0 = cs_low_cnt; v0 = valid_cnt; d0 = done_cnt;
    push_seq(10'h020);
    push_seq(10'h034);
    do_start(10'h020, 4'd2, s);
    repeat (5) @(negedge clk);
    chk("s6_busy_fetch", 32'(busy), 32'd1);
    base = 10'h200; num = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid_fall("s6");
    repeat (3) @(negedge clk);
    chk("s6_busy_gap", 32'(busy), 32'd1);
    chk("s6_cs_gap", 32'(bus.o_mem_CS), 32'd1);
    base = 10'h300; num = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("s6", d);
    end_check("s6", cs0, v0, d0, 42, 40, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
